if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Pipeline stage between instruction fetch and decode in the 16-bit core.
- Registers each fetched instruction with its PC and splits it into fields. imm8 goes straight to the immediate extender; rs/rd go to the register file.
- Two-entry elastic buffer (output register plus skid register) with valid/ready on both sides, so fetch never loses an instruction when decode stalls.
- Branch flush discards everything held.

Parameters:
- IW, 16, instruction width; field positions below assume 16.
- PCW, 16, program counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  IW  instruction word.
- in_pc  in  PCW  address of in_instr.
- flush  in  1  branch/jump taken; discard all held instructions.
- out_valid  out  1  fields below are valid.
- out_ready  in  1  decode consumes this cycle.
- out_instr  out  IW  held instruction.
- out_pc  out  PCW  held PC.
- out_pc_inc  out  PCW  out_pc + 1, wraps modulo 2^PCW.
- out_op  out  2  out_instr[15:14].
- out_rs  out  3  out_instr[13:11].
- out_rd  out  3  out_instr[10:8].
- out_imm8  out  8  out_instr[7:0]; feeds the immediate extender unmodified.
- out_op3  out  4  out_instr[7:4], the ALU sub-op when out_op==2'b11.

Behaviour:
- Reset (async, rst_n low):
  - main and skid entries invalid.
  - out_valid=0, in_ready=1.
  - out_instr, out_pc and all field outputs 0; out_pc_inc=1.
  - Release is synchronous to clk; the first accept is possible on the first edge after release.
- State is {main_v, skid_v}. Legal states: EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) must never occur.
- Handshakes:
  - in_ready = !skid_v, registered, not combinational from out_ready.
  - out_valid = main_v.
  - accept = in_valid & in_ready.
  - take = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY + accept -> ONE; main loads the input.
  - ONE + accept + take -> ONE; main loads the input (throughput 1/cycle).
  - ONE + accept + !take -> FULL; skid loads the input, main holds.
  - ONE + !accept + take -> EMPTY.
  - FULL + take -> ONE; main loads skid, skid cleared. No accept is possible because in_ready=0.
  - Otherwise hold.
- Flush:
  - flush=1 at an edge -> EMPTY regardless of accept or take. The input presented that cycle is dropped.
  - in_ready stays 1 during flush; fetch must treat a flush-cycle accept as discarded.
  - out_valid=0 on the next cycle.
- Data stability:
  - While out_valid & !out_ready, all out_* outputs hold exactly.
  - Field outputs are combinational slices of the main register, so they have zero added latency.
- Latency: accept to out_valid is 1 cycle.
- Ordering: strict FIFO. The skid entry never overtakes main.
- Data registers need no reset beyond the zeroing above; only the valid bits matter functionally.
- Reset mid-operation: every held instruction is lost and no stale out_valid pulse appears.

Test Plan:
- Reset then stream: in_valid=1 with instructions 0x8312@pc0, 0xC345@pc1, 0x4A07@pc2, out_ready=1.
  - Response: out_valid from cycle 1; out_imm8 = 0x12, 0x45, 0x07 on consecutive cycles.
  - For 0xC345: out_op=3, out_rs=0, out_rd=3, out_op3=4.
  - in_ready stays 1 throughout.
- Backpressure: hold out_ready=0 while sending A=0x1111, B=0x2222, C=0x3333.
  - Response: A and B are accepted and in_ready drops to 0 after B; C is held by fetch.
  - Release out_ready: outputs are A, B, C in order with no duplicates and none dropped.
- Flush in FULL: after state FULL, pulse flush=1 with in_valid=1, in_instr=0x5555.
  - Response: next cycle out_valid=0, in_ready=1, and 0x5555 never appears at the output.
- PC wrap: in_pc=0xFFFF.
  - Response: out_pc=0xFFFF, out_pc_inc=0x0000.
- Async reset mid-stream: drive rst_n low between clock edges while in FULL.
  - Response: out_valid=0 immediately without waiting for an edge, in_ready=1, out_pc_inc=1. After release, the first accepted instruction appears alone.
- Random valid/ready: run 10k cycles with 50% random in_valid and out_ready, checked against a reference FIFO model.
  - Response: identical output sequence, and state (0,1) is never reached.

Source files
------------

// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - fetch/decode handshake bundle for the IF/ID stage
// Purpose: groups the fetch-side input, the flush strobe and the decode-side
//          output of if_id_stage into one bundle.
// Ports (signals):
//   in_valid/in_ready/in_instr/in_pc   fetch -> stage handshake and payload
//   flush                              discard everything held in the stage
//   out_valid/out_ready                stage -> decode handshake
//   out_instr/out_pc/out_pc_inc        held instruction, its PC and PC+1
//   out_op/out_rs/out_rd/out_imm8/out_op3  decoded field slices
// Modports: master = fetch/decode environment, slave = the stage itself.
interface if_id_stage_if #(
  parameter int IW  = 16,
  parameter int PCW = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  in_instr;
  logic [PCW-1:0] in_pc;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [IW-1:0]  out_instr;
  logic [PCW-1:0] out_pc;
  logic [PCW-1:0] out_pc_inc;
  logic [1:0]     out_op;
  logic [2:0]     out_rs;
  logic [2:0]     out_rd;
  logic [7:0]     out_imm8;
  logic [3:0]     out_op3;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pc_inc,
           out_op, out_rs, out_rd, out_imm8, out_op3
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pc_inc,
           out_op, out_rs, out_rd, out_imm8, out_op3
  );
endinterface

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with two-entry skid buffer
// Purpose: registers each fetched instruction with its PC, splits it into
//          decode fields and absorbs one extra instruction when decode stalls
//          so fetch never loses one. flush empties the stage.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    if_id_stage_if.slave: fetch handshake in, decode handshake out,
//          flush, held instruction/PC/PC+1 and field slices
module if_id_stage #(
  parameter int IW  = 16,
  parameter int PCW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  if_id_stage_if.slave  bus
);

  // Occupancy encoded as {main_v, skid_v}; 2'b01 is unreachable.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic           main_v;
  logic           skid_v;
  logic [IW-1:0]  main_instr;
  logic [PCW-1:0] main_pc;
  logic [IW-1:0]  skid_instr;
  logic [PCW-1:0] skid_pc;
  logic           accept;
  logic           take;

  // in_ready depends only on the skid flag, never on out_ready, so there is
  // no combinational path from decode back to fetch.
  assign accept = bus.in_valid & ~skid_v;
  assign take   = main_v & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v     <= 1'b0;
      skid_v     <= 1'b0;
      main_instr <= '0;
      main_pc    <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (bus.flush) begin
      // Input presented in a flush cycle is dropped along with held entries.
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      case ({main_v, skid_v})
        ST_EMPTY: begin
          if (accept) begin
            main_v     <= 1'b1;
            main_instr <= bus.in_instr;
            main_pc    <= bus.in_pc;
          end
        end
        ST_ONE: begin
          if (accept && take) begin
            main_instr <= bus.in_instr;
            main_pc    <= bus.in_pc;
          end else if (accept) begin
            // Decode stalled: park the newcomer behind main.
            skid_v     <= 1'b1;
            skid_instr <= bus.in_instr;
            skid_pc    <= bus.in_pc;
          end else if (take) begin
            main_v <= 1'b0;
          end
        end
        ST_FULL: begin
          if (take) begin
            skid_v     <= 1'b0;
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
          end
        end
        default: begin
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = ~skid_v;
  assign bus.out_valid  = main_v;
  assign bus.out_instr  = main_instr;
  assign bus.out_pc     = main_pc;
  assign bus.out_pc_inc = main_pc + 1'b1;

  // Field slices straight off the main register: no added latency.
  assign bus.out_op   = main_instr[15:14];
  assign bus.out_rs   = main_instr[13:11];
  assign bus.out_rd   = main_instr[10:8];
  assign bus.out_imm8 = main_instr[7:0];
  assign bus.out_op3  = main_instr[7:4];

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed and random self-checking bench for if_id_stage
module tb_if_id_stage;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  logic [31:0] q[$];

  if_id_stage_if #(.IW(16), .PCW(16)) bus ();

  if_id_stage #(.IW(16), .PCW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 16'h0, 16'h0);

    // Reset state
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_instr", 32'(bus.out_instr), 32'h0);
    chk("rst_out_pc", 32'(bus.out_pc), 32'h0);
    chk("rst_out_pc_inc", 32'(bus.out_pc_inc), 32'h1);
    chk("rst_imm8", 32'(bus.out_imm8), 32'h0);

    // Stream with decode always ready
    #9;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h8312, 16'd0);
    step();
    chk("s0_valid", 32'(bus.out_valid), 32'd1);
    chk("s0_imm8", 32'(bus.out_imm8), 32'h12);
    chk("s0_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 16'hC345, 16'd1);
    step();
    chk("s1_imm8", 32'(bus.out_imm8), 32'h45);
    chk("s1_op", 32'(bus.out_op), 32'd3);
    chk("s1_rs", 32'(bus.out_rs), 32'd0);
    chk("s1_rd", 32'(bus.out_rd), 32'd3);
    chk("s1_op3", 32'(bus.out_op3), 32'd4);
    chk("s1_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 16'h4A07, 16'd2);
    step();
    chk("s2_imm8", 32'(bus.out_imm8), 32'h07);
    chk("s2_pc", 32'(bus.out_pc), 32'd2);
    chk("s2_pc_inc", 32'(bus.out_pc_inc), 32'd3);
    chk("s2_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b0, 16'h0, 16'h0);
    step();
    chk("s3_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure: A, B absorbed, C held by fetch
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h1111, 16'd10);
    step();
    chk("bp_a_instr", 32'(bus.out_instr), 32'h1111);
    chk("bp_a_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 16'h2222, 16'd11);
    step();
    chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_a", 32'(bus.out_instr), 32'h1111);
    drive(1'b1, 16'h3333, 16'd12);
    step();
    chk("bp_still_a", 32'({bus.out_instr, bus.out_pc}), {16'h1111, 16'd10});
    chk("bp_still_full", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    step();
    chk("bp_b", 32'({bus.out_instr, bus.out_pc}), {16'h2222, 16'd11});
    chk("bp_b_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("bp_c", 32'({bus.out_instr, bus.out_pc}), {16'h3333, 16'd12});
    chk("bp_c_valid", 32'(bus.out_valid), 32'd1);
    drive(1'b0, 16'h0, 16'h0);
    step();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Flush while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h1234, 16'd20);
    step();
    drive(1'b1, 16'h2345, 16'd21);
    step();
    chk("fl_full", 32'(bus.in_ready), 32'd0);
    bus.flush = 1'b1;
    drive(1'b1, 16'h5555, 16'd22);
    step();
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    // Flush from EMPTY with a live input: in_ready stays 1, input dropped
    step();
    chk("fl2_valid", 32'(bus.out_valid), 32'd0);
    chk("fl2_in_ready", 32'(bus.in_ready), 32'd1);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 16'h0, 16'h0);
    step();
    chk("fl_no_5555", 32'(bus.out_valid), 32'd0);

    // PC wrap
    drive(1'b1, 16'h0001, 16'hFFFF);
    step();
    chk("wrap_pc", 32'(bus.out_pc), 32'hFFFF);
    chk("wrap_pc_inc", 32'(bus.out_pc_inc), 32'h0000);
    drive(1'b0, 16'h0, 16'h0);
    step();

    // Async reset in FULL, between clock edges
    bus.out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 16'd40);
    step();
    drive(1'b1, 16'hBBBB, 16'd41);
    step();
    chk("ar_full", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_in_ready", 32'(bus.in_ready), 32'd1);
    chk("ar_pc_inc", 32'(bus.out_pc_inc), 32'd1);
    drive(1'b0, 16'h0, 16'h0);
    step();
    #3;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h7777, 16'd30);
    step();
    chk("ar_first", 32'({bus.out_instr, bus.out_pc}), {16'h7777, 16'd30});
    drive(1'b0, 16'h0, 16'h0);
    step();
    chk("ar_alone", 32'(bus.out_valid), 32'd0);

    // Random traffic against a FIFO model of depth 2
    q.delete();
    for (int i = 0; i < 10000; i++) begin
      logic acc;
      logic tk;
      chk("rnd_in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      chk("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("rnd_no_01", 32'({bus.out_valid, bus.in_ready} == 2'b00), 32'd0);
      if (q.size() > 0)
        chk("rnd_data", {bus.out_instr, bus.out_pc}, q[0]);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_instr  = 16'($urandom);
      bus.in_pc     = 16'(i);
      bus.flush     = ($urandom_range(0, 31) == 0);
      acc = bus.in_valid && (q.size() < 2);
      tk  = bus.out_ready && (q.size() > 0);
      if (bus.flush) begin
        q.delete();
      end else begin
        if (tk) void'(q.pop_front());
        if (acc) q.push_back({bus.in_instr, bus.in_pc});
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
